// File: rtl/cwru_transceiver_rx.sv
// Serial byte receiver: two-flop synchronizer, mid-bit sampling FSM, framing check, hex display.
// Define CWRU_RX_PARITY_EN to compile in the even-parity bit between data and stop.
module cwru_transceiver_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERR,
  output logic [6:0] HEX0
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef CWRU_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s, rx_prev;
  logic [1:0]    flush;
  logic          armed;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par_err, par_err_nxt;
  logic          load, err;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift;
    par_err_nxt = par_err;
    load        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        // armed blocks a line that was already low when reset released
        if (armed && rx_prev && !rx_s) begin
          state_nxt   = START;
          cnt_nxt     = '0;
          bit_nxt     = '0;
          par_err_nxt = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[7:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef CWRU_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef CWRU_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          par_err_nxt = (rx_s != ^shift);
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rx_s && !par_err) load = 1'b1;
          else                  err  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (RST) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      flush    <= 2'b00;
      armed    <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_err  <= 1'b0;
      RX_DATA  <= 8'h00;
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      HEX0     <= SEG_DASH;
    end else begin
      rx_meta  <= RX_IN;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      // rx_s carries the reset value until the synchronizer has flushed twice
      flush    <= {flush[0], 1'b1};
      if (flush[1] && rx_s) armed <= 1'b1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_err  <= par_err_nxt;
      RX_VALID <= load;
      RX_ERR   <= err;
      if (load)     RX_DATA <= shift;
      if (RX_VALID) HEX0    <= seg_decode(RX_DATA[3:0]);
    end
  end

endmodule

// File: tb/tb_cwru_transceiver_rx.sv
// Scoreboard bench for cwru_transceiver_rx: directed frames plus random frames against a
// frame-level model; honours CWRU_RX_PARITY_EN when defined.
module tb_cwru_transceiver_rx;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef CWRU_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + H + 9 * C + (PAR_EN ? C : 0);
  localparam logic [6:0] DASH = 7'b0111111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ERR;
  logic [6:0] HEX0;

  cwru_transceiver_rx #(.CLKS_PER_BIT(C)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR), .HEX0(HEX0)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;
  bit         hex_pending = 1'b0;
  logic [6:0] hex_exp;
  bit         lat_ok;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Active-low segments derived from the list of lit segments per digit.
  function automatic logic [6:0] seg_model(input logic [3:0] d);
    string      lit;
    logic [6:0] s;
    case (d)
      4'h0: lit = "abcdef";  4'h1: lit = "bc";      4'h2: lit = "abdeg";   4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";    4'h5: lit = "acdfg";   4'h6: lit = "acdefg";  4'h7: lit = "abc";
      4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";  4'hA: lit = "abcefg";  4'hB: lit = "cdefg";
      4'hC: lit = "adef";    4'hD: lit = "bcdeg";   4'hE: lit = "adefg";   default: lit = "aefg";
    endcase
    s = 7'h7F;
    for (int i = 0; i < lit.len(); i++) begin
      int idx;
      idx = int'(lit[i]) - 97;
      s[idx] = 1'b0;
    end
    return s;
  endfunction

  task automatic send_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    send_bit(1'b1, n);
  endtask

  // Callers are aligned to a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip);
    exp_t e;
    e.t0     = cyc + 1;
    e.is_err = !stop || (PAR_EN && par_flip);
    e.data   = e.is_err ? last_good : d;
    if (!e.is_err) last_good = d;
    sb.push_back(e);
    send_bit(1'b0, C);
    for (int i = 0; i < 8; i++) send_bit(d[i], C);
`ifdef CWRU_RX_PARITY_EN
    send_bit((^d) ^ par_flip, C);
`endif
    send_bit(stop, C);
    if (!stop) idle(4);
  endtask

  always @(negedge CLK) begin
    if (hex_pending) begin
      check("hex0_after_valid", HEX0, hex_exp);
      hex_pending = 1'b0;
    end
    if (RX_VALID || RX_ERR) begin
      check("valid_err_exclusive", RX_VALID & RX_ERR, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {RX_VALID, RX_ERR}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_is_err", RX_ERR, mon_e.is_err);
        check("rx_data", RX_DATA, mon_e.data);
        lat_ok = (cyc - mon_e.t0 >= LAT - 1) && (cyc - mon_e.t0 <= LAT + 1);
        check("latency_ok", lat_ok, 1);
        if (RX_VALID) begin
          hex_pending = 1'b1;
          hex_exp     = seg_model(mon_e.data[3:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    bit         stop, pf;

    RST = 1'b1;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_rx_data", RX_DATA, 8'h00);
    check("reset_rx_valid", RX_VALID, 0);
    check("reset_rx_err", RX_ERR, 0);
    check("reset_hex0", HEX0, DASH);
    RST = 1'b0;
    idle(6);

    send_frame(8'h35, 1'b1, 1'b0);
    idle(10);
    send_frame(8'hA7, 1'b0, 1'b0);
    idle(10);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(10);

    // short low glitch must be rejected silently
    send_bit(1'b0, 4);
    idle(3 * C);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(10);

    // reset in the middle of data bit 4, then line held low
    d = 8'h96;
    send_bit(1'b0, C);
    for (int i = 0; i < 4; i++) send_bit(d[i], C);
    send_bit(d[4], H);
    RST = 1'b1;
    RX_IN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    last_good = 8'h00;
    check("midframe_reset_rx_data", RX_DATA, 8'h00);
    check("midframe_reset_hex0", HEX0, DASH);
    check("midframe_reset_pulses", {RX_VALID, RX_ERR}, 0);
    send_bit(1'b0, 39);
    idle(10);
    check("held_low_rx_data", RX_DATA, 8'h00);
    check("held_low_hex0", HEX0, DASH);
    send_frame(8'h0C, 1'b1, 1'b0);
    idle(10);

`ifdef CWRU_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle(10);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(10);
`endif

    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pf   = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(d, stop, pf);
      idle($urandom_range(0, 12));
    end

    for (int i = 0; i < 30 * C && sb.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge CLK);
    check("final_rx_data", RX_DATA, last_good);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
